// File: rtl/posit_field_encoder.sv
// Packs sign/scale/fraction fields into a posit<N,ES> word with RNE rounding and maxpos/minpos saturation.
// Latency: 2 cycles from input accept to out_valid; 1 word per cycle when not stalled.
// Backpressure: in_ready = !out_valid | out_ready; a stall freezes both stages. Optional out_inexact via POSIT_ENC_INEXACT_EN.
module posit_field_encoder #(
    parameter int N  = 9,
    parameter int ES = 3,
    parameter int FW = 8,
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [SW-1:0] in_scale,
    input  logic [FW-1:0] in_frac,
    input  logic          in_zero,
    input  logic          in_nar,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_posit
`ifdef POSIT_ENC_INEXACT_EN
    ,
    output logic          out_inexact
`endif
);

    localparam int KW   = SW - ES;
    localparam int BW   = N + ES + FW;
    localparam int MAXK = N - 2;
    localparam logic [N-1:0] ONE_N = N'(1);
    localparam logic [N-2:0] MINPOS = (N-1)'(1);

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: split scale into regime run k and exponent e, flag out-of-range k
    logic [KW-1:0] in_k;
    int            in_kv;
    assign in_k  = in_scale[SW-1:ES];
    assign in_kv = int'($signed(in_k));

    logic          s1_valid, s1_sign, s1_zero, s1_nar, s1_sat_hi, s1_sat_lo;
    logic [KW-1:0] s1_k;
    logic [ES-1:0] s1_e;
    logic [FW-1:0] s1_frac;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_zero   <= 1'b0;
            s1_nar    <= 1'b0;
            s1_sat_hi <= 1'b0;
            s1_sat_lo <= 1'b0;
            s1_k      <= '0;
            s1_e      <= '0;
            s1_frac   <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign   <= in_sign;
                s1_zero   <= in_zero;
                s1_nar    <= in_nar;
                s1_sat_hi <= (in_kv > MAXK);
                s1_sat_lo <= (in_kv < -MAXK);
                s1_k      <= in_k;
                s1_e      <= in_scale[ES-1:0];
                s1_frac   <= in_frac;
            end
        end
    end

    // Stage 2: regime is left-aligned in an N-bit slot; e and frac follow it after rlen bits
    int            kv;
    int            rlen;
    logic [N-1:0]  regime;
    logic [BW-1:0] body;
    assign kv = int'($signed(s1_k));

    always_comb begin
        regime = '0;
        rlen   = 0;
        if (kv >= 0) begin
            regime = {N{1'b1}} << (N - 1 - kv);
            rlen   = kv + 2;
        end else begin
            regime = ONE_N << (N - 1 + kv);
            rlen   = 1 - kv;
        end
        body = {regime, {(ES+FW){1'b0}}} | ({s1_e, s1_frac, {N{1'b0}}} >> rlen);
    end

    logic [N-2:0] field;
    logic         guard, sticky, rnd_up;
    logic [N-1:0] rnd_sum;
    logic [N-2:0] mag;
    logic [N-1:0] pos_word, signed_word, enc_word;

    assign field   = body[BW-1 -: N-1];
    assign guard   = body[BW-N];
    assign sticky  = |body[BW-N-1:0];
    assign rnd_up  = guard && (field[0] || sticky);
    assign rnd_sum = {1'b0, field} + {{(N-1){1'b0}}, rnd_up};

    always_comb begin
        mag = rnd_sum[N-2:0];
        if (s1_sat_hi || rnd_sum[N-1]) begin
            mag = {(N-1){1'b1}};
        end else if (s1_sat_lo || (rnd_sum[N-2:0] == '0)) begin
            mag = MINPOS;
        end
        pos_word    = {1'b0, mag};
        signed_word = s1_sign ? (~pos_word + ONE_N) : pos_word;
        enc_word    = signed_word;
        if (s1_nar) begin
            enc_word = {1'b1, {(N-1){1'b0}}};
        end else if (s1_zero) begin
            enc_word = '0;
        end
    end

`ifdef POSIT_ENC_INEXACT_EN
    logic inexact_c;
    assign inexact_c = !(s1_nar || s1_zero) && (guard || sticky || s1_sat_hi || s1_sat_lo);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            out_posit   <= '0;
`ifdef POSIT_ENC_INEXACT_EN
            out_inexact <= 1'b0;
`endif
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_posit   <= enc_word;
`ifdef POSIT_ENC_INEXACT_EN
                out_inexact <= inexact_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_posit_field_encoder.sv
// Randomized and directed bench for posit_field_encoder (N=9, ES=3, FW=8, SW=8).
module tb_posit_field_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid, in_ready, in_sign, in_zero, in_nar;
    logic [7:0] in_scale, in_frac;
    logic       out_valid, out_ready;
    logic [8:0] out_posit;
`ifdef POSIT_ENC_INEXACT_EN
    logic       out_inexact;
`endif

    always #5 clk = ~clk;

    posit_field_encoder #(.N(9), .ES(3), .FW(8), .SW(8)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sign(in_sign),
        .in_scale(in_scale),
        .in_frac(in_frac),
        .in_zero(in_zero),
        .in_nar(in_nar),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_posit(out_posit)
`ifdef POSIT_ENC_INEXACT_EN
        ,
        .out_inexact(out_inexact)
`endif
    );

    typedef struct {
        logic [8:0] p;
        logic       inx;
    } exp_t;

    exp_t       sb[$];
    exp_t       item;
    int         checks = 0;
    int         errors = 0;
    bit         rand_mode = 0;
    bit         use_dir = 0;
    logic [8:0] dir_p;
    logic       dir_inx;
    logic [8:0] held;
    logic [8:0] mp;
    logic       mi;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: build the posit bit string as a list of bits, then round the first 8
    function automatic void ref_enc(input bit sgn, input int scale, input int frac,
                                    input bit zero, input bit nar,
                                    output logic [8:0] p, output logic inx);
        int e, k, mag;
        bit q[$];
        bit g, st;
        inx = 1'b0;
        if (nar) begin
            p = 9'h100;
            return;
        end
        if (zero) begin
            p = 9'h000;
            return;
        end
        e = ((scale % 8) + 8) % 8;
        k = (scale - e) / 8;
        if (k > 7) begin
            mag = 255;
            inx = 1'b1;
        end else if (k < -7) begin
            mag = 1;
            inx = 1'b1;
        end else begin
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = 2; i >= 0; i--) q.push_back(bit'((e >> i) & 1));
            for (int i = 7; i >= 0; i--) q.push_back(bit'((frac >> i) & 1));
            mag = 0;
            for (int i = 0; i < 8; i++) mag = mag * 2 + int'(q[i]);
            g  = q[8];
            st = 1'b0;
            for (int i = 9; i < q.size(); i++) st = st | q[i];
            if (g && ((mag % 2 == 1) || st)) mag++;
            if (mag > 255) mag = 255;
            if (mag == 0) mag = 1;
            inx = g | st;
        end
        p = sgn ? 9'((512 - mag) % 512) : 9'(mag);
    endfunction

    // Scoreboard monitor: sampled at negedge, between drive (posedge+1) and the next active edge
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 32'(out_posit), 32'h1ff);
                end else begin
                    item = sb.pop_front();
                    check("posit", 32'(out_posit), 32'(item.p));
`ifdef POSIT_ENC_INEXACT_EN
                    check("inexact", 32'(out_inexact), 32'(item.inx));
`endif
                end
            end
            if (in_valid && in_ready) begin
                if (use_dir) begin
                    item.p   = dir_p;
                    item.inx = dir_inx;
                end else begin
                    ref_enc(in_sign, int'($signed(in_scale)), int'(in_frac), in_zero, in_nar, mp, mi);
                    item.p   = mp;
                    item.inx = mi;
                end
                sb.push_back(item);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send(input logic s, input logic [7:0] sc, input logic [7:0] fr,
                        input logic z, input logic n);
        bit acc;
        in_valid = 1'b1;
        in_sign  = s;
        in_scale = sc;
        in_frac  = fr;
        in_zero  = z;
        in_nar   = n;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic senddir(input logic s, input logic [7:0] sc, input logic [7:0] fr,
                           input logic z, input logic n, input logic [8:0] ep, input logic ei);
        use_dir = 1'b1;
        dir_p   = ep;
        dir_inx = ei;
        send(s, sc, fr, z, n);
        use_dir = 1'b0;
    endtask

    task automatic drain();
        rand_mode = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_scale  = '0;
        in_frac   = '0;
        in_zero   = 1'b0;
        in_nar    = 1'b0;
        out_ready = 1'b1;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_posit", 32'(out_posit), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Known encodings, rounding ties and saturation
        senddir(0, 8'd0,    8'h00, 0, 0, 9'h080, 0);
        senddir(1, 8'd0,    8'h00, 0, 0, 9'h180, 0);
        senddir(0, 8'd1,    8'h00, 0, 0, 9'h088, 0);
        senddir(0, 8'd0,    8'h80, 0, 0, 9'h084, 0);
        senddir(0, 8'd8,    8'h00, 0, 0, 9'h0C0, 0);
        senddir(0, 8'hFF,   8'h00, 0, 0, 9'h078, 0);
        senddir(0, 8'd0,    8'h10, 0, 0, 9'h080, 1);
        senddir(0, 8'd0,    8'h30, 0, 0, 9'h082, 1);
        senddir(0, 8'd0,    8'h11, 0, 0, 9'h081, 1);
        senddir(0, 8'd100,  8'h00, 0, 0, 9'h0FF, 1);
        senddir(0, 8'h9C,   8'h00, 0, 0, 9'h001, 1);
        senddir(1, 8'd100,  8'h00, 0, 0, 9'h101, 1);
        senddir(1, 8'd5,    8'h3C, 1, 1, 9'h100, 0);
        senddir(1, 8'd5,    8'h3C, 1, 0, 9'h000, 0);
        drain();

        // Back-pressure: fill both stages, hold output for 3 cycles, then release
        out_ready = 1'b0;
        senddir(0, 8'd1, 8'h00, 0, 0, 9'h088, 0);
        senddir(0, 8'd8, 8'h00, 0, 0, 9'h0C0, 0);
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_scale = 8'd0;
        in_frac  = 8'h11;
        in_zero  = 1'b0;
        in_nar   = 1'b0;
        held     = out_posit;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_hold", 32'(out_posit), 32'h088);
            tick();
        end
        check("stall_held_same", 32'(out_posit), 32'(held));
        out_ready = 1'b1;
        senddir(0, 8'd0, 8'h11, 0, 0, 9'h081, 1);
        senddir(0, 8'hFF, 8'h00, 0, 0, 9'h078, 0);
        drain();

        // Randomized traffic with random gaps and random downstream stalls
        rand_mode = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
        end
        drain();

        // Reset with two words in flight
        out_ready = 1'b0;
        senddir(0, 8'd1, 8'h00, 0, 0, 9'h088, 0);
        senddir(0, 8'd8, 8'h00, 0, 0, 9'h0C0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_posit", 32'(out_posit), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_quiet", 32'(out_valid), 32'd0);
            tick();
        end
        senddir(1, 8'd0, 8'h00, 0, 0, 9'h180, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
